// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential restoring divider.
package seq_divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 4;

  // 2'd3 is unused; the FSM treats it as IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int count_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_divider_addsub.sv
// Combinational ripple-carry adder/subtractor: mode=1 computes a - b.
module addsub_unit
  import seq_divider_pkg::*;
#(
  parameter int W = DIV_WIDTH_DEFAULT + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mode,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] b_x;
  logic [W:0]   carry;

  assign b_x      = b ^ {W{mode}};
  assign carry[0] = mode;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      assign sum[gi]     = a[gi] ^ b_x[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b_x[gi]) | (carry[gi] & (a[gi] ^ b_x[gi]));
    end
  endgenerate

  assign cout = carry[W];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = count_width(WIDTH);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH:0]   rem_acc;
  logic [WIDTH-1:0] quo_acc;
  logic [WIDTH-1:0] div_op;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   r_iter;
  logic [WIDTH-1:0] q_iter;
  logic             no_borrow;
  logic             accept;
  logic             zero_div;
  logic             last_iter;
  logic             unused_rem_msb;

  assign accept    = start && (state != ST_RUN);
  assign zero_div  = (divisor == '0);
  assign last_iter = (count == CW'(WIDTH - 1));

  // The remainder is always below the divisor, so its MSB is zero before each shift.
  assign unused_rem_msb = rem_acc[WIDTH];
  assign r_shift = {rem_acc[WIDTH-1:0], quo_acc[WIDTH-1]};

  addsub_unit #(.W(WIDTH + 1)) u_addsub (
    .a    (r_shift),
    .b    ({1'b0, div_op}),
    .mode (1'b1),
    .sum  (trial),
    .cout (no_borrow)
  );

  assign r_iter = no_borrow ? trial : r_shift;
  assign q_iter = {quo_acc[WIDTH-2:0], no_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_RUN: state_next = last_iter ? ST_DONE : ST_RUN;
      default: begin
        if (start) begin
          state_next = zero_div ? ST_DONE : ST_RUN;
        end
      end
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_acc     <= '0;
      quo_acc     <= '0;
      div_op      <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (zero_div) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        rem_acc     <= '0;
        quo_acc     <= dividend;
        div_op      <= divisor;
        count       <= '0;
        div_by_zero <= 1'b0;
      end
    end else if (state == ST_RUN) begin
      rem_acc <= r_iter;
      quo_acc <= q_iter;
      count   <= count + 1'b1;
      if (last_iter) begin
        quotient  <= q_iter;
        remainder <= r_iter[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=4 (directed + exhaustive) and WIDTH=8 (random).
module tb_seq_divider;

  localparam int W4 = 4;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          start4 = 1'b0;
  logic [W4-1:0] dd4 = '0, dv4 = '0;
  logic          busy4, done4, dbz4;
  logic [W4-1:0] q4, r4;

  logic          start8 = 1'b0;
  logic [W8-1:0] dd8 = '0, dv8 = '0;
  logic          busy8, done8, dbz8;
  logic [W8-1:0] q8, r8;

  seq_divider #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .dividend(dd4), .divisor(dv4),
    .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(dbz4)
  );

  seq_divider #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dd8), .divisor(dv8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int dd;
    int dv;
    int q;
    int r;
    int dbz;
    int edge_n;
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];
  exp_t e4, e8;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: plain integer division; divide-by-zero yields all ones and the dividend.
  function automatic exp_t model(input int dd, input int dv, input int w, input int k);
    exp_t e;
    e.dd     = dd;
    e.dv     = dv;
    e.q      = (dv == 0) ? ((1 << w) - 1) : dd / dv;
    e.r      = (dv == 0) ? dd : dd % dv;
    e.dbz    = (dv == 0) ? 1 : 0;
    e.edge_n = k + ((dv == 0) ? 0 : w);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done4 === 1'b1) begin
      if (sb4.size() == 0) begin
        check("w4 unexpected done", 1, 0);
      end else begin
        e4 = sb4.pop_front();
        $display("w4 %0d/%0d -> q=%0d r=%0d dbz=%0d at edge %0d", e4.dd, e4.dv, q4, r4, dbz4, edge_cnt);
        check("w4 quotient", int'(q4), e4.q);
        check("w4 remainder", int'(r4), e4.r);
        check("w4 div_by_zero", int'(dbz4), e4.dbz);
        check("w4 done edge", edge_cnt, e4.edge_n);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done8 === 1'b1) begin
      if (sb8.size() == 0) begin
        check("w8 unexpected done", 1, 0);
      end else begin
        e8 = sb8.pop_front();
        $display("w8 %0d/%0d -> q=%0d r=%0d dbz=%0d at edge %0d", e8.dd, e8.dv, q8, r8, dbz8, edge_cnt);
        check("w8 quotient", int'(q8), e8.q);
        check("w8 remainder", int'(r8), e8.r);
        check("w8 div_by_zero", int'(dbz8), e8.dbz);
        check("w8 done edge", edge_cnt, e8.edge_n);
      end
    end
  end

  // One WIDTH=4 operation from IDLE, checking busy each cycle until done.
  task automatic op4(input int dd, input int dv);
    int k;
    @(posedge clk); #1;
    start4 = 1'b1; dd4 = 4'(dd); dv4 = 4'(dv);
    @(posedge clk); #1;
    k = edge_cnt;
    sb4.push_back(model(dd, dv, W4, k));
    start4 = 1'b0; dd4 = 4'($urandom); dv4 = 4'($urandom);
    for (int i = 0; i <= W4; i++) begin
      @(negedge clk);
      check("w4 busy", int'(busy4), (dv != 0 && i < W4) ? 1 : 0);
    end
  endtask

  task automatic op8(input int dd, input int dv);
    int k;
    @(posedge clk); #1;
    start8 = 1'b1; dd8 = 8'(dd); dv8 = 8'(dv);
    @(posedge clk); #1;
    k = edge_cnt;
    sb8.push_back(model(dd, dv, W8, k));
    start8 = 1'b0; dd8 = 8'($urandom); dv8 = 8'($urandom);
    repeat (W8 + 1) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", int'(busy4), 0);
    check("reset done", int'(done4), 0);
    check("reset quotient", int'(q4), 0);
    check("reset remainder", int'(r4), 0);
    check("reset div_by_zero", int'(dbz4), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic and boundary operands
    op4(13, 3);
    op4(15, 1);
    op4(2, 7);
    op4(15, 15);
    op4(0, 5);
    op4(9, 0);
    op4(8, 2);

    // start reasserted mid-RUN with new operands is ignored
    @(posedge clk); #1;
    start4 = 1'b1; dd4 = 4'd13; dv4 = 4'd3;
    @(posedge clk); #1;
    k = edge_cnt;
    sb4.push_back(model(13, 3, W4, k));
    dd4 = 4'd6; dv4 = 4'd2;
    repeat (2) @(posedge clk);
    #1 start4 = 1'b0;
    repeat (6) @(negedge clk);
    check("held quotient", int'(q4), 13 / 3);
    check("held remainder", int'(r4), 13 % 3);

    // Back-to-back: start held through the DONE cycle
    @(posedge clk); #1;
    start4 = 1'b1; dd4 = 4'd10; dv4 = 4'd3;
    @(posedge clk); #1;
    k = edge_cnt;
    sb4.push_back(model(10, 3, W4, k));
    dd4 = 4'd7; dv4 = 4'd2;
    repeat (W4 + 1) @(posedge clk);
    #1;
    sb4.push_back(model(7, 2, W4, k + W4 + 1));
    start4 = 1'b0;
    repeat (W4 + 2) @(posedge clk);

    // Reset asserted mid-RUN aborts without a result
    @(posedge clk); #1;
    start4 = 1'b1; dd4 = 4'd13; dv4 = 4'd3;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy", int'(busy4), 0);
    check("async reset done", int'(done4), 0);
    check("async reset quotient", int'(q4), 0);
    check("async reset remainder", int'(r4), 0);
    check("async reset div_by_zero", int'(dbz4), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    op4(13, 3);

    // Exhaustive WIDTH=4
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op4(a, b);
      end
    end

    // Random sweep WIDTH=8
    for (int n = 0; n < 40; n++) begin
      op8(int'($urandom_range(0, 255)),
          ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255)));
    end
    op8(255, 1);
    op8(1, 255);

    repeat (4) @(posedge clk);
    check("w4 scoreboard drained", sb4.size(), 0);
    check("w8 scoreboard drained", sb8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
